// File: rtl/egk_bin_stream.sv
// Order-k Exp-Golomb binarizer: streams one EGk bin string per request, MSB-first.
// Define EGK_PACKED_OUT_EN to also build the packed codeword / length / overflow outputs.
module egk_bin_stream #(
    parameter int VALUE_WIDTH = 8,
    parameter int K_WIDTH     = 3,
    parameter int BIN_WIDTH   = 32,
    parameter int LEN_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [VALUE_WIDTH-1:0] N_i,
    input  logic [K_WIDTH-1:0]     k_i,
    input  logic                   signed_i,
    output logic                   ready_o,
    output logic                   bin_o,
    output logic                   bin_valid_o,
    input  logic                   bin_ready_i,
    output logic [BIN_WIDTH-1:0]   code_o,
    output logic [LEN_WIDTH-1:0]   bin_length_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int M_W  = VALUE_WIDTH + 1;
    localparam int KC_W = $clog2(M_W + (1 << K_WIDTH)) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFIX,
        S_SUFFIX,
        S_DONE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [M_W-1:0]  r_rem,   w_rem_nxt;
    logic [KC_W-1:0] r_kc,    w_kc_nxt;

    logic [M_W-1:0]  w_sext, w_map, w_pow, w_shr;
    logic            w_ge, w_bin, w_hs, w_accept;

    // se mapping in one extra bit so the most negative input maps without overflow.
    assign w_sext = {N_i[VALUE_WIDTH-1], N_i};
    always_comb begin
        if (!signed_i)
            w_map = {1'b0, N_i};
        else if (!N_i[VALUE_WIDTH-1] && (N_i != '0))
            w_map = (w_sext << 1) - M_W'(1);
        else
            w_map = M_W'(0) - (w_sext << 1);
    end

    // 2^kc is only representable below M_W; beyond that r can never reach it.
    assign w_pow = M_W'(1) << r_kc;
    assign w_ge  = (r_kc < KC_W'(M_W)) && (r_rem >= w_pow);
    assign w_shr = r_rem >> (r_kc - KC_W'(1));

    always_comb begin
        w_bin = 1'b0;
        case (r_state)
            S_PREFIX: w_bin = w_ge;
            S_SUFFIX: w_bin = w_shr[0];
            default:  w_bin = 1'b0;
        endcase
    end

    assign bin_valid_o = (r_state == S_PREFIX) || (r_state == S_SUFFIX);
    assign bin_o       = w_bin;
    assign ready_o     = (r_state == S_IDLE) && !rst;
    assign done_o      = (r_state == S_DONE);
    assign w_hs        = bin_valid_o && bin_ready_i;
    assign w_accept    = (r_state == S_IDLE) && start_i;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_kc_nxt    = r_kc;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_rem_nxt   = w_map;
                    w_kc_nxt    = KC_W'(k_i);
                    w_state_nxt = S_PREFIX;
                end
            end
            S_PREFIX: begin
                if (w_hs) begin
                    if (w_ge) begin
                        w_rem_nxt = r_rem - w_pow;
                        w_kc_nxt  = r_kc + KC_W'(1);
                    end else if (r_kc == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_SUFFIX;
                    end
                end
            end
            S_SUFFIX: begin
                if (w_hs) begin
                    w_kc_nxt = r_kc - KC_W'(1);
                    if (r_kc == KC_W'(1))
                        w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_kc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_kc    <= w_kc_nxt;
        end
    end

`ifdef EGK_PACKED_OUT_EN
    logic [BIN_WIDTH-1:0] r_code;
    logic [LEN_WIDTH-1:0] r_len;

    // Shift-in packing: on overflow the oldest bins fall off the top, length stays exact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_code <= '0;
            r_len  <= '0;
        end else if (w_accept) begin
            r_code <= '0;
            r_len  <= '0;
        end else if (w_hs) begin
            r_code <= {r_code[BIN_WIDTH-2:0], w_bin};
            r_len  <= r_len + LEN_WIDTH'(1);
        end
    end

    assign code_o       = r_code;
    assign bin_length_o = r_len;
    assign err_o        = done_o && (r_len > LEN_WIDTH'(BIN_WIDTH));
`else
    assign code_o       = '0;
    assign bin_length_o = '0;
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_egk_bin_stream.sv
// Self-checking bench for egk_bin_stream: directed corner cases plus randomized
// requests and back-pressure, compared against a closed-form EGk reference model.
module tb_egk_bin_stream;

    localparam int VW = 8;
    localparam int KW = 3;
    localparam int BW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [VW-1:0] N_i;
    logic [KW-1:0] k_i;
    logic          signed_i;
    logic          ready_o;
    logic          bin_o;
    logic          bin_valid_o;
    logic          bin_ready_i;
    logic [BW-1:0] code_o;
    logic [LW-1:0] bin_length_o;
    logic          done_o;
    logic          err_o;

    int n_checks = 0;
    int n_errors = 0;

    egk_bin_stream #(
        .VALUE_WIDTH(VW),
        .K_WIDTH    (KW),
        .BIN_WIDTH  (BW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .N_i         (N_i),
        .k_i         (k_i),
        .signed_i    (signed_i),
        .ready_o     (ready_o),
        .bin_o       (bin_o),
        .bin_valid_o (bin_valid_o),
        .bin_ready_i (bin_ready_i),
        .code_o      (code_o),
        .bin_length_o(bin_length_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Closed form: w = m + 2^k has nb bits; the prefix is (nb-1-k) ones, a zero,
    // then the low nb-1 bits of w.
    task automatic egk_model(input logic [VW-1:0] n, input int k, input bit sgn,
                             output longint code, output int len);
        longint v, m, w;
        int     nb, p;
        if (sgn) begin
            v = (n >= (1 << (VW - 1))) ? longint'(n) - (longint'(1) << VW) : longint'(n);
            m = (v > 0) ? 2 * v - 1 : -2 * v;
        end else begin
            m = longint'(n);
        end
        w  = m + (longint'(1) << k);
        nb = 0;
        while ((w >> nb) != 0) nb++;
        p    = nb - 1 - k;
        code = (((longint'(1) << p) - 1) << nb) | (w & ((longint'(1) << (nb - 1)) - 1));
        len  = p + nb;
    endtask

    // stall_mode: 0 consumer always ready, 1 alternating, 2 random
    task automatic run_req(input logic [VW-1:0] n, input int k, input bit sgn,
                           input int stall_mode, input bit hold_start, input bit chk_lat);
        longint      exp_code;
        int          exp_len;
        logic [63:0] got_bins;
        int          nbins, c, done_c;
        bit          held_v, busy_ready;
        logic        held_b;
        longint      exp_packed;

        egk_model(n, k, sgn, exp_code, exp_len);

        c = 0;
        while (!ready_o && c < 100) begin
            @(posedge clk); #1; c++;
        end
        check("ready_wait", ready_o, 1);

        start_i     = 1'b1;
        N_i         = n;
        k_i         = KW'(k);
        signed_i    = sgn;
        bin_ready_i = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start_i = 1'b0;

        c = 1; nbins = 0; done_c = 0; got_bins = '0; held_v = 0; busy_ready = 0;
        while (c < 200) begin
            case (stall_mode)
                0:       bin_ready_i = 1'b1;
                1:       bin_ready_i = c[0];
                default: bin_ready_i = 1'($urandom_range(0, 1));
            endcase
            if (held_v && bin_valid_o) check("bin_hold", bin_o, held_b);
            held_v = bin_valid_o && !bin_ready_i;
            held_b = bin_o;
            if (ready_o) busy_ready = 1;
            if (bin_valid_o && bin_ready_i) begin
                got_bins = {got_bins[62:0], bin_o};
                nbins++;
            end
            if (done_o) begin
                done_c = c;
                break;
            end
            @(posedge clk); #1; c++;
        end
        start_i = 1'b0;

        check("done_seen", 64'(done_c != 0), 1);
        check("ready_busy", 64'(busy_ready), 0);
        check("bin_count", 64'(nbins), 64'(exp_len));
        check("bins", got_bins, 64'(exp_code));
        if (chk_lat) check("done_lat", 64'(done_c), 64'(exp_len + 1));
`ifdef EGK_PACKED_OUT_EN
        exp_packed = exp_code & ((longint'(1) << BW) - 1);
        check("code", 64'(code_o), 64'(exp_packed));
        check("len", 64'(bin_length_o), 64'(exp_len));
        check("err", 64'(err_o), 64'(exp_len > BW));
`else
        exp_packed = 0;
        check("code", 64'(code_o), 64'(exp_packed));
        check("len", 64'(bin_length_o), 0);
        check("err", 64'(err_o), 0);
`endif
        @(posedge clk); #1;
        check("done_pulse", done_o, 0);
        check("ready_after", ready_o, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; N_i = '0; k_i = '0; signed_i = 1'b0; bin_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bin_valid_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ready", ready_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", ready_o, 1);
        check("post_rst_code", 64'(code_o), 0);
        check("post_rst_len", 64'(bin_length_o), 0);
        check("post_rst_err", err_o, 0);
        check("post_rst_valid", bin_valid_o, 0);

        run_req(8'd5,   1, 0, 0, 0, 1);   // 1011
        run_req(8'hFD,  1, 1, 0, 0, 1);   // -3 -> 6 -> 110000
        run_req(8'hFF,  1, 1, 0, 0, 1);   // -1 -> 2 -> 1000
        run_req(8'd0,   1, 0, 0, 0, 1);   // 00
        run_req(8'd7,   0, 0, 0, 0, 1);   // 1110000
        run_req(8'd5,   1, 0, 1, 1, 0);   // back-pressure with start held
        run_req(8'd255, 0, 0, 0, 0, 1);   // 17 bins, overflows BW
        run_req(8'h80,  0, 1, 0, 0, 1);   // most negative -> 256
        run_req(8'd0,   0, 0, 0, 0, 1);   // single bin
        run_req(8'd255, 7, 0, 2, 0, 0);

        // Reset in the middle of the suffix of N=7, k=0.
        start_i = 1'b1; N_i = 8'd7; k_i = '0; signed_i = 1'b0; bin_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("mid_suffix_valid", bin_valid_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_valid", bin_valid_o, 0);
        check("abort_bin", bin_o, 0);
        check("abort_done", done_o, 0);
        check("abort_ready", ready_o, 0);
        check("abort_code", 64'(code_o), 0);
        check("abort_len", 64'(bin_length_o), 0);
        check("abort_err", err_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready_after", ready_o, 1);
        check("abort_done_after", done_o, 0);
        run_req(8'd5, 1, 0, 0, 0, 1);

        for (int i = 0; i < 40; i++) begin
            run_req(VW'($urandom), $urandom_range(0, (1 << KW) - 1), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
